// File: rtl/uart_tx_frame.sv
// uart_tx_frame: UART transmit framer.
// Serializes one DATA_WIDTH-bit word per request as
// start(0), data LSB first, optional parity, stop(1).
// Each bit lasts CLKS_PER_BIT clocks.
//
// Build option: define UART_TX_PARITY_EN to build the parity bit.
// Without it, PAR_EN and PAR_TYP are ignored and no parity bit is sent.
//
// Handshake: a request is accepted on a rising edge where the FSM is idle
// and DATA_VALID=1. BUSY is high from the cycle after that accept edge
// until the stop bit ends. DATA_VALID seen while BUSY=1 is dropped, not
// queued.
//
// dbg_state_o exposes the FSM encoding:
// 0 idle, 1 start, 2 data, 3 parity, 4 stop.
module uart_tx_frame #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic [2:0]            dbg_state_o
);

  // Keep both counters at least one bit wide so CLKS_PER_BIT=1 and
  // DATA_WIDTH=1 still elaborate.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    tx_q;
  logic                    busy_q;
  logic                    bit_wrap_d;
  logic [IDX_W-1:0]        idx_d;

`ifdef UART_TX_PARITY_EN
  logic                    par_en_q;
  logic                    par_bit_q;
`else
  // The parity inputs stay on the port list but nothing reads them here.
  logic                    unused_par_inputs;
  assign unused_par_inputs = PAR_EN ^ PAR_TYP;
`endif

  // Bit-period end and the index of the next data bit to drive.
  always_comb begin
    bit_wrap_d = (cnt_q == CNT_MAX);
    idx_d      = idx_q + 1'b1;
  end

  // Framing FSM. TX_OUT and BUSY are registered, and each next value is
  // loaded together with the state change. This keeps the line glitch-free
  // and changing only at bit boundaries.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (DATA_VALID) begin
            data_q    <= P_DATA;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= PAR_EN;
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
`endif
            cnt_q     <= '0;
            idx_q     <= '0;
            state_q   <= S_START;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        default: begin
          if (!bit_wrap_d) begin
            cnt_q <= cnt_q + 1'b1;
          end else begin
            cnt_q <= '0;
            case (state_q)
              S_START: begin
                state_q <= S_DATA;
                idx_q   <= '0;
                tx_q    <= data_q[0];
              end
              S_DATA: begin
                if (idx_q == IDX_MAX) begin
                  idx_q <= '0;
`ifdef UART_TX_PARITY_EN
                  if (par_en_q) begin
                    state_q <= S_PARITY;
                    tx_q    <= par_bit_q;
                  end else begin
                    state_q <= S_STOP;
                    tx_q    <= 1'b1;
                  end
`else
                  state_q <= S_STOP;
                  tx_q    <= 1'b1;
`endif
                end else begin
                  idx_q <= idx_d;
                  tx_q  <= data_q[idx_d];
                end
              end
`ifdef UART_TX_PARITY_EN
              S_PARITY: begin
                state_q <= S_STOP;
                tx_q    <= 1'b1;
              end
`endif
              default: begin
                // End of the stop bit. Any unexpected encoding also
                // falls back to idle.
                state_q <= S_IDLE;
                tx_q    <= 1'b1;
                busy_q  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign TX_OUT      = tx_q;
  assign BUSY        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed testbench for uart_tx_frame, built with CLKS_PER_BIT=4.
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge, once per clock cycle.
module tb_uart_tx_frame;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic          tx_out;
  logic          busy;
  logic [2:0]    dbg_state;

  int tests_run;
  int tests_failed;

  uart_tx_frame #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .CLK        (clk),
    .RST        (rst),
    .P_DATA     (p_data),
    .DATA_VALID (data_valid),
    .PAR_EN     (par_en),
    .PAR_TYP    (par_typ),
    .TX_OUT     (tx_out),
    .BUSY       (busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Present a request for one edge and return at the first sample point
  // of the start bit. With hold=1, DATA_VALID is left asserted.
  task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                      input logic hold);
    @(negedge clk);
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    @(negedge clk);
    if (!hold) data_valid = 1'b0;
  endtask

  // Record nbits bit periods starting at the current sample point. The
  // first sample of each bit is that bit's value. A later sample that
  // differs counts as a glitch. BUSY-high samples are counted until BUSY
  // drops, within a bound. When inj_at is non-negative, a one-cycle
  // DATA_VALID pulse carrying inj_data is driven at that sample index
  // (the start bit's first sample has index 1).
  task automatic run_frame(input int nbits, input int inj_at,
                           input logic [DW-1:0] inj_data,
                           output logic [15:0] bits, output int busy_cnt,
                           output int glitches);
    int s;
    int guard;
    logic v;
    bits     = '0;
    busy_cnt = 0;
    glitches = 0;
    s        = 0;
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < CPB; c++) begin
        s++;
        v = tx_out;
        if (c == 0) bits[b] = v;
        else if (v !== bits[b]) glitches++;
        if (busy === 1'b1) busy_cnt++;
        if (s == inj_at) begin
          p_data     = inj_data;
          data_valid = 1'b1;
        end else if (s == inj_at + 1) begin
          data_valid = 1'b0;
        end
        @(negedge clk);
      end
    end
    guard = 0;
    while (busy !== 1'b0 && guard < 200) begin
      busy_cnt++;
      guard++;
      @(negedge clk);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst        = 1'b1;
    data_valid = 1'b1;
    p_data     = 8'h00;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    // The first reset edge sees DATA_VALID=1. Reset must win.
    repeat (3) @(negedge clk);
    data_valid = 1'b0;
    tests_run++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_vs_valid: tx=%b busy=%b expected tx=1 busy=0", tx_out, busy);
    end
    tests_run++;
    if (dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_state: state=%0d expected 0", dbg_state);
    end
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      tests_run++;
      if (tx_out !== 1'b1 || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL idle_cycle%0d: tx=%b busy=%b expected tx=1 busy=0", i, tx_out, busy);
      end
    end
  endtask

  task automatic test_basic_frame;
    logic [15:0] bits;
    int bc, gl;
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    run_frame(10, -1, '0, bits, bc, gl);
    tests_run++;
    if (bits[9:0] !== 10'b11_0100_1010) begin
      tests_failed++;
      $display("FAIL basic_bits: got %b expected 1101001010", bits[9:0]);
    end
    tests_run++;
    if (bc !== 40) begin
      tests_failed++;
      $display("FAIL basic_busy: got %0d expected 40", bc);
    end
    tests_run++;
    if (gl !== 0) begin
      tests_failed++;
      $display("FAIL basic_glitch: got %0d expected 0", gl);
    end
  endtask

  task automatic test_parity;
    logic [DW-1:0] pd [3] = '{8'hA5, 8'hA5, 8'hFF};
    logic          pt [3] = '{1'b0, 1'b1, 1'b1};
`ifdef UART_TX_PARITY_EN
    logic          pb [3] = '{1'b0, 1'b1, 1'b1};
`endif
    logic [15:0] bits;
    int bc, gl;
    for (int t = 0; t < 3; t++) begin
      repeat (3) @(negedge clk);
      send(pd[t], 1'b1, pt[t], 1'b0);
`ifdef UART_TX_PARITY_EN
      run_frame(11, -1, '0, bits, bc, gl);
      tests_run++;
      if (bits[10:0] !== {1'b1, pb[t], pd[t], 1'b0}) begin
        tests_failed++;
        $display("FAIL parity_bits%0d: got %b expected %b", t, bits[10:0],
                 {1'b1, pb[t], pd[t], 1'b0});
      end
      tests_run++;
      if (bc !== 44) begin
        tests_failed++;
        $display("FAIL parity_busy%0d: got %0d expected 44", t, bc);
      end
`else
      // Parity is not built, so PAR_EN=1 must leave a plain 10-bit frame.
      run_frame(10, -1, '0, bits, bc, gl);
      tests_run++;
      if (bits[9:0] !== {1'b1, pd[t], 1'b0}) begin
        tests_failed++;
        $display("FAIL noparity_bits%0d: got %b expected %b", t, bits[9:0],
                 {1'b1, pd[t], 1'b0});
      end
      tests_run++;
      if (bc !== 40) begin
        tests_failed++;
        $display("FAIL noparity_busy%0d: got %0d expected 40", t, bc);
      end
`endif
      tests_run++;
      if (gl !== 0) begin
        tests_failed++;
        $display("FAIL parity_glitch%0d: got %0d expected 0", t, gl);
      end
    end
  endtask

  task automatic test_ignored_request;
    logic [15:0] bits;
    int bc, gl, bad;
    repeat (3) @(negedge clk);
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    // Sample 20 falls inside data bit 3.
    run_frame(10, 20, 8'hFF, bits, bc, gl);
    tests_run++;
    if (bits[9:0] !== {1'b1, 8'h3C, 1'b0}) begin
      tests_failed++;
      $display("FAIL ignored_bits: got %b expected %b", bits[9:0], {1'b1, 8'h3C, 1'b0});
    end
    tests_run++;
    if (bc !== 40) begin
      tests_failed++;
      $display("FAIL ignored_busy: got %0d expected 40", bc);
    end
    bad = 0;
    for (int i = 0; i < 4 * CPB; i++) begin
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
      @(negedge clk);
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL ignored_no_second: got %0d active samples expected 0", bad);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] bits1, bits2;
    int bc1, bc2, gl, idle;
    repeat (3) @(negedge clk);
    send(8'h55, 1'b0, 1'b0, 1'b1);
    run_frame(10, -1, '0, bits1, bc1, gl);
    idle = 0;
    while (busy === 1'b0 && idle < 50) begin
      if (tx_out !== 1'b1) idle = 100;
      idle++;
      @(negedge clk);
      data_valid = 1'b0;
    end
    run_frame(10, -1, '0, bits2, bc2, gl);
    tests_run++;
    if (bits1[9:0] !== {1'b1, 8'h55, 1'b0} || bits2[9:0] !== {1'b1, 8'h55, 1'b0}) begin
      tests_failed++;
      $display("FAIL b2b_bits: got %b / %b expected %b", bits1[9:0], bits2[9:0],
               {1'b1, 8'h55, 1'b0});
    end
    tests_run++;
    if (idle !== 1) begin
      tests_failed++;
      $display("FAIL b2b_busy_low: got %0d cycles expected 1", idle);
    end
    tests_run++;
    if (bc1 !== 40 || bc2 !== 40) begin
      tests_failed++;
      $display("FAIL b2b_busy: got %0d / %0d expected 40", bc1, bc2);
    end
  endtask

  task automatic test_midframe_reset;
    logic [15:0] bits;
    int bc, gl;
    repeat (3) @(negedge clk);
    send(8'hA5, 1'b0, 1'b0, 1'b0);
    // Sample 1 is now in view. Move to sample 18, inside data bit 3.
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests_run++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || dbg_state !== 3'd0) begin
      tests_failed++;
      $display("FAIL midreset: tx=%b busy=%b state=%0d expected 1 0 0", tx_out, busy, dbg_state);
    end
    repeat (3) @(negedge clk);
    send(8'h81, 1'b0, 1'b0, 1'b0);
    run_frame(10, -1, '0, bits, bc, gl);
    tests_run++;
    if (bits[9:0] !== {1'b1, 8'h81, 1'b0} || bc !== 40) begin
      tests_failed++;
      $display("FAIL after_reset_frame: bits %b busy %0d expected %b busy 40", bits[9:0], bc,
               {1'b1, 8'h81, 1'b0});
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_basic_frame();
    test_parity();
    test_ignored_request();
    test_back_to_back();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
